// File: rtl/md_sched.sv
// Multiply/divide sequencer owning HI/LO: runs MULT/MULTU/DIV/DIVU with a fixed
// busy latency, services MTHI/MTLO, and raises the F/D stall for waiting MD instructions.
module md_sched #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_hi,
  input  logic        md_use_D,
  output logic [31:0] md_out,
  output logic        busy,
  output logic        stall_req
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [DATA_W-1:0]   hi, hi_nxt, lo, lo_nxt;
  logic [DATA_W-1:0]   a_q, a_nxt, b_q, b_nxt;
  logic [1:0]          op_q, op_nxt;

  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic [DATA_W-1:0]   abs_a, abs_b, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [DATA_W-1:0]   res_hi, res_lo;
  logic                res_wr;

  // Result of the latched operation; only consumed on the final busy edge.
  always_comb begin
    prod_s = {{DATA_W{a_q[DATA_W-1]}}, a_q} * {{DATA_W{b_q[DATA_W-1]}}, b_q};
    prod_u = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    abs_a  = a_q[DATA_W-1] ? (DATA_W'(0) - a_q) : a_q;
    abs_b  = b_q[DATA_W-1] ? (DATA_W'(0) - b_q) : b_q;
    q_mag  = abs_a / abs_b;
    r_mag  = abs_a % abs_b;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    q_s    = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? (DATA_W'(0) - q_mag) : q_mag;
    r_s    = a_q[DATA_W-1] ? (DATA_W'(0) - r_mag) : r_mag;
    q_u    = a_q / b_q;
    r_u    = a_q % b_q;
    res_wr = 1'b1;
    case (op_q)
      2'd0: begin res_hi = prod_s[2*DATA_W-1:DATA_W]; res_lo = prod_s[DATA_W-1:0]; end
      2'd1: begin res_hi = prod_u[2*DATA_W-1:DATA_W]; res_lo = prod_u[DATA_W-1:0]; end
      2'd2: begin res_hi = r_s; res_lo = q_s; res_wr = (b_q != '0); end
      default: begin res_hi = r_u; res_lo = q_u; res_wr = (b_q != '0); end
    endcase
  end

  // Next-state: accept only in IDLE, count down in RUN, commit on the last busy edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    lo_nxt    = lo;
    a_nxt     = a_q;
    b_nxt     = b_q;
    op_nxt    = op_q;
    case (state)
      IDLE: begin
        if (md_start) begin
          case (md_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              a_nxt     = rs_val;
              b_nxt     = rt_val;
              op_nxt    = md_op[1:0];
              cnt_nxt   = md_op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
              state_nxt = RUN;
            end
            OP_MTHI: hi_nxt = rs_val;
            OP_MTLO: lo_nxt = rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          if (res_wr) begin
            hi_nxt = res_hi;
            lo_nxt = res_lo;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      op_q  <= op_nxt;
    end
  end

  assign busy      = (state == RUN);
  assign md_out    = rd_hi ? hi : lo;
  assign stall_req = md_use_D & (busy | md_start);

endmodule
